// File: rtl/phold_mc_pkg.sv
// Shared MC port definitions for the PHOLD memory path: field widths,
// command/response encodings and a small contention helper.
package phold_mc_pkg;

    localparam int MC_CMD_W  = 3;
    localparam int MC_SCMD_W = 4;
    localparam int MC_VADR_W = 48;
    localparam int MC_SIZE_W = 2;
    localparam int MC_DATA_W = 64;

    localparam logic [MC_CMD_W-1:0] MC_CMD_RD      = 3'd1;
    localparam logic [MC_CMD_W-1:0] MC_CMD_WR      = 3'd2;
    localparam logic [MC_CMD_W-1:0] MC_RSP_RD_DATA = 3'd2;
    localparam logic [MC_CMD_W-1:0] MC_RSP_WR_CMP  = 3'd3;

    // True when at least two bits of the (zero-extended) vector are set.
    function automatic logic multi_req(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping N-1 -> 0.
// N must be a power of two so the pointer arithmetic wraps naturally.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic           grant_vld,
    output logic [IDW-1:0] grant_id,
    output logic [IDW-1:0] next_ptr
);

    logic [IDW-1:0] idx;

    // Scan from ptr upward; the first active request claims the grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + IDW'(i);
            if (en && !grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        grant    = grant_vld ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;
        next_ptr = grant_id + IDW'(1);
    end

endmodule

// File: rtl/mc_port_arbiter.sv
// Funnels NUM_CLIENTS core request channels onto one MC port. Requests are
// tagged with the client ID in the rtnctl MSBs; responses are routed back by
// that tag. Also counts cycles in which two or more clients contend.
module mc_port_arbiter
    import phold_mc_pkg::*;
#(
    parameter int NUM_CLIENTS     = 4,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int ID_WID          = $clog2(NUM_CLIENTS),
    parameter int CL_RTNCTL_WID   = MC_RTNCTL_WIDTH - ID_WID
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CLIENTS-1:0]             cl_rq_vld,
    input  logic [MC_CMD_W*NUM_CLIENTS-1:0]    cl_rq_cmd,
    input  logic [MC_SCMD_W*NUM_CLIENTS-1:0]   cl_rq_scmd,
    input  logic [MC_VADR_W*NUM_CLIENTS-1:0]   cl_rq_vadr,
    input  logic [MC_SIZE_W*NUM_CLIENTS-1:0]   cl_rq_size,
    input  logic [CL_RTNCTL_WID*NUM_CLIENTS-1:0] cl_rq_rtnctl,
    input  logic [MC_DATA_W*NUM_CLIENTS-1:0]   cl_rq_data,
    output logic [NUM_CLIENTS-1:0]             cl_rq_grant,
    output logic [NUM_CLIENTS-1:0]             cl_rs_vld,
    output logic [MC_CMD_W-1:0]                cl_rs_cmd,
    output logic [MC_SCMD_W-1:0]               cl_rs_scmd,
    output logic [CL_RTNCTL_WID-1:0]           cl_rs_rtnctl,
    output logic [MC_DATA_W-1:0]               cl_rs_data,
    input  logic [NUM_CLIENTS-1:0]             cl_rs_stall,
    output logic                               mc_rq_vld,
    output logic [MC_CMD_W-1:0]                mc_rq_cmd,
    output logic [MC_SCMD_W-1:0]               mc_rq_scmd,
    output logic [MC_VADR_W-1:0]               mc_rq_vadr,
    output logic [MC_SIZE_W-1:0]               mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0]         mc_rq_rtnctl,
    output logic [MC_DATA_W-1:0]               mc_rq_data,
    output logic                               mc_rq_flush,
    input  logic                               mc_rq_stall,
    input  logic                               mc_rs_vld,
    input  logic [MC_CMD_W-1:0]                mc_rs_cmd,
    input  logic [MC_SCMD_W-1:0]               mc_rs_scmd,
    input  logic [MC_RTNCTL_WIDTH-1:0]         mc_rs_rtnctl,
    input  logic [MC_DATA_W-1:0]               mc_rs_data,
    output logic                               mc_rs_stall,
    output logic [63:0]                        q_conf_cnt
);

    logic                   rq_vld_p1;
    logic                   rq_free;
    logic [ID_WID-1:0]      ptr_q;
    logic                   arb_vld;
    logic [ID_WID-1:0]      arb_id;
    logic [ID_WID-1:0]      arb_next;
    logic                   rs_vld_p1;
    logic [ID_WID-1:0]      rs_id_p1;
    logic                   rs_load;
    logic                   rs_drain;

    // The register can take a new request when empty or emptying this cycle.
    // Grants are also masked while reset is asserted so every output reads 0.
    assign rq_free = ~rq_vld_p1 | ~mc_rq_stall;

    rr_arbiter #(.N(NUM_CLIENTS), .IDW(ID_WID)) u_arb (
        .req       (cl_rq_vld),
        .ptr       (ptr_q),
        .en        (rq_free & rst_n),
        .grant     (cl_rq_grant),
        .grant_vld (arb_vld),
        .grant_id  (arb_id),
        .next_ptr  (arb_next)
    );

    assign mc_rq_vld   = rq_vld_p1;
    assign mc_rq_flush = 1'b0;

    // Request stage: latch the granted client's fields, tag rtnctl with its ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_vld_p1    <= 1'b0;
            ptr_q        <= '0;
            mc_rq_cmd    <= '0;
            mc_rq_scmd   <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_size   <= '0;
            mc_rq_rtnctl <= '0;
            mc_rq_data   <= '0;
        end else if (arb_vld) begin
            rq_vld_p1    <= 1'b1;
            ptr_q        <= arb_next;
            mc_rq_cmd    <= cl_rq_cmd[int'(arb_id)*MC_CMD_W +: MC_CMD_W];
            mc_rq_scmd   <= cl_rq_scmd[int'(arb_id)*MC_SCMD_W +: MC_SCMD_W];
            mc_rq_vadr   <= cl_rq_vadr[int'(arb_id)*MC_VADR_W +: MC_VADR_W];
            mc_rq_size   <= cl_rq_size[int'(arb_id)*MC_SIZE_W +: MC_SIZE_W];
            mc_rq_rtnctl <= {arb_id, cl_rq_rtnctl[int'(arb_id)*CL_RTNCTL_WID +: CL_RTNCTL_WID]};
            mc_rq_data   <= cl_rq_data[int'(arb_id)*MC_DATA_W +: MC_DATA_W];
        end else if (!mc_rq_stall) begin
            rq_vld_p1    <= 1'b0;
        end
    end

    // Only the stall of the client owning the held response matters.
    assign mc_rs_stall = rs_vld_p1 & cl_rs_stall[rs_id_p1];
    assign rs_load     = mc_rs_vld & ~mc_rs_stall;
    assign rs_drain    = rs_vld_p1 & ~cl_rs_stall[rs_id_p1];

    // Response stage: capture routing ID and payload; load may overlap a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_vld_p1    <= 1'b0;
            rs_id_p1     <= '0;
            cl_rs_cmd    <= '0;
            cl_rs_scmd   <= '0;
            cl_rs_rtnctl <= '0;
            cl_rs_data   <= '0;
        end else if (rs_load) begin
            rs_vld_p1    <= 1'b1;
            rs_id_p1     <= mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_WID];
            cl_rs_cmd    <= mc_rs_cmd;
            cl_rs_scmd   <= mc_rs_scmd;
            cl_rs_rtnctl <= mc_rs_rtnctl[CL_RTNCTL_WID-1:0];
            cl_rs_data   <= mc_rs_data;
        end else if (rs_drain) begin
            rs_vld_p1    <= 1'b0;
        end
    end

    // Steer the response valid to the tagged client only.
    always_comb begin
        cl_rs_vld = '0;
        if (rs_vld_p1) cl_rs_vld[rs_id_p1] = 1'b1;
    end

    // Contention counter: cycles where two or more clients are requesting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_conf_cnt <= '0;
        else if (multi_req(64'(cl_rq_vld))) q_conf_cnt <= q_conf_cnt + 64'd1;
    end

endmodule
